// File: rtl/rr_logb_marshaller_n.sv
`default_nettype none
// ============================================================================
// Module   : rr_logb_marshaller_n
// Purpose  : Packs NUM_IN variable-length logb fragments into one contiguous
//            beat through an elastic PIPE_STAGES-deep pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module rr_logb_marshaller_n #(
    parameter  int NUM_IN      = 4,
    parameter  int IN_WIDTH    = 64,
    parameter  int PIPE_STAGES = 2,
    localparam int LEN_IN      = $clog2(IN_WIDTH + 1),
    localparam int LEN_OUT     = $clog2(NUM_IN * IN_WIDTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*IN_WIDTH-1:0]   in_data,
    input  logic [NUM_IN*LEN_IN-1:0]     in_len,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [NUM_IN*IN_WIDTH-1:0]   out_data,
    output logic [LEN_OUT-1:0]           out_len,
    output logic [NUM_IN-1:0]            out_mask,
    input  logic                         out_ready,
    output logic                         err_len,
    output logic [31:0]                  beat_cnt
);

    localparam int                C_TOT_W = NUM_IN * IN_WIDTH;
    localparam logic [IN_WIDTH-1:0] C_ONES = '1;

    logic [C_TOT_W-1:0]        w_frag_pk;
    logic [NUM_IN*LEN_OUT-1:0] w_off_pk;
    logic [LEN_OUT-1:0]        w_tot;
    logic [LEN_IN-1:0]         w_eff;
    logic [LEN_IN-1:0]         w_raw;
    logic                      w_len_err;
    logic                      w_any_valid;
    logic                      w_accept;
    logic [PIPE_STAGES:0]      w_go;
    logic                      w_full;
    logic [C_TOT_W-1:0]        w_merge;
    logic [C_TOT_W-1:0]        w_out_data;

    logic [PIPE_STAGES-1:0]    r_vld;
    logic [LEN_OUT-1:0]        r_len [PIPE_STAGES];
    logic [NUM_IN-1:0]         r_msk [PIPE_STAGES];
    logic [C_TOT_W-1:0]        r_s1_frag;
    logic [NUM_IN*LEN_OUT-1:0] r_s1_off;
    logic                      r_err;
    logic [31:0]               r_beat_cnt;

    // Clamp lengths, strip bits above each length and build prefix offsets.
    always_comb begin
        w_frag_pk = '0;
        w_off_pk  = '0;
        w_tot     = '0;
        w_len_err = 1'b0;
        w_eff     = '0;
        w_raw     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_raw = in_len[i*LEN_IN +: LEN_IN];
            if (!in_valid[i]) begin
                w_eff = '0;
            end else if (w_raw > LEN_IN'(IN_WIDTH)) begin
                w_eff     = LEN_IN'(IN_WIDTH);
                w_len_err = 1'b1;
            end else begin
                w_eff = w_raw;
            end
            w_frag_pk[i*IN_WIDTH +: IN_WIDTH] =
                in_data[i*IN_WIDTH +: IN_WIDTH] & ~(C_ONES << w_eff);
            w_off_pk[i*LEN_OUT +: LEN_OUT] = w_tot;
            w_tot = w_tot + LEN_OUT'(w_eff);
        end
    end

    // A stage can load when it, or every stage below it, is able to move on.
    always_comb begin
        w_go   = '0;
        w_full = 1'b0;
        w_go[PIPE_STAGES] = out_ready;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            w_full = 1'b1;
            for (int j = k; j < PIPE_STAGES; j++) begin
                w_full = w_full & r_vld[j];
            end
            w_go[k] = !w_full || out_ready;
        end
    end

    assign w_any_valid = |in_valid;
    assign in_ready    = !rst && w_go[0];
    assign w_accept    = w_any_valid && in_ready;

    always_comb begin
        w_merge = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_merge = w_merge |
                (C_TOT_W'(r_s1_frag[i*IN_WIDTH +: IN_WIDTH]) << r_s1_off[i*LEN_OUT +: LEN_OUT]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_s1_frag <= '0;
            r_s1_off  <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_len[k] <= '0;
                r_msk[k] <= '0;
            end
        end else begin
            if (w_go[0]) begin
                r_vld[0] <= w_any_valid;
                if (w_any_valid) begin
                    r_s1_frag <= w_frag_pk;
                    r_s1_off  <= w_off_pk;
                    r_len[0]  <= w_tot;
                    r_msk[0]  <= in_valid;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_go[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_len[k] <= r_len[k-1];
                        r_msk[k] <= r_msk[k-1];
                    end
                end
            end
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_single
            assign w_out_data = w_merge;
        end else begin : g_multi
            // Merge result is registered in stage 2; later stages only carry it.
            logic [C_TOT_W-1:0] r_dat [PIPE_STAGES-1:1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 1; k < PIPE_STAGES; k++) begin
                        r_dat[k] <= '0;
                    end
                end else begin
                    if (w_go[1] && r_vld[0]) begin
                        r_dat[1] <= w_merge;
                    end
                    for (int k = 2; k < PIPE_STAGES; k++) begin
                        if (w_go[k] && r_vld[k-1]) begin
                            r_dat[k] <= r_dat[k-1];
                        end
                    end
                end
            end

            assign w_out_data = r_dat[PIPE_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            if (w_accept && w_len_err) begin
                r_err <= 1'b1;
            end
            if (r_vld[PIPE_STAGES-1] && out_ready) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign out_valid = r_vld[PIPE_STAGES-1];
    assign out_data  = w_out_data;
    assign out_len   = r_len[PIPE_STAGES-1];
    assign out_mask  = r_msk[PIPE_STAGES-1];
    assign err_len   = r_err;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_logb_marshaller_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_logb_marshaller_n
// Purpose  : Directed self-checking bench for rr_logb_marshaller_n (4 x 8b, 2 stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_logb_marshaller_n;

    localparam int NUM_IN      = 4;
    localparam int IN_WIDTH    = 8;
    localparam int PIPE_STAGES = 2;
    localparam int LEN_IN      = 4;
    localparam int LEN_OUT     = 6;

    logic                       clk;
    logic                       rst;
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN*IN_WIDTH-1:0] in_data;
    logic [NUM_IN*LEN_IN-1:0]   in_len;
    logic                       in_ready;
    logic                       out_valid;
    logic [NUM_IN*IN_WIDTH-1:0] out_data;
    logic [LEN_OUT-1:0]         out_len;
    logic [NUM_IN-1:0]          out_mask;
    logic                       out_ready;
    logic                       err_len;
    logic [31:0]                beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rr_logb_marshaller_n #(
        .NUM_IN      (NUM_IN),
        .IN_WIDTH    (IN_WIDTH),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_mask  (out_mask),
        .out_ready (out_ready),
        .err_len   (err_len),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frag(input int idx, input logic v, input logic [3:0] len, input logic [7:0] dat);
        in_valid[idx]           = v;
        in_len[idx*LEN_IN +: 4] = len;
        in_data[idx*8 +: 8]     = dat;
    endtask

    task automatic clr();
        in_valid = '0;
        in_len   = '0;
        in_data  = '0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        clr();

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_len",   64'(out_len),   64'd0);
        chk("rst_out_mask",  64'(out_mask),  64'd0);
        chk("rst_err_len",   64'(err_len),   64'd0);
        chk("rst_beat_cnt",  64'(beat_cnt),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic packing: 0xF (len 4) then 0xA5 (len 8); invalid in1 contributes nothing
        frag(0, 1'b1, 4'd4, 8'hFF);
        frag(1, 1'b0, 4'd8, 8'hFF);
        frag(2, 1'b1, 4'd8, 8'hA5);
        frag(3, 1'b1, 4'd0, 8'h00);
        tick();
        clr();
        chk("basic_lat1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_data",  64'(out_data),  64'h0000_0A5F);
        chk("basic_len",   64'(out_len),   64'd12);
        chk("basic_mask",  64'(out_mask),  64'b1101);
        tick();
        chk("basic_beat_cnt", 64'(beat_cnt), 64'd1);
        chk("basic_drained",  64'(out_valid), 64'd0);

        // All four fragments full
        frag(0, 1'b1, 4'd8, 8'h11);
        frag(1, 1'b1, 4'd8, 8'h22);
        frag(2, 1'b1, 4'd8, 8'h33);
        frag(3, 1'b1, 4'd8, 8'h44);
        tick();
        clr();
        tick();
        chk("full_data", 64'(out_data), 64'h4433_2211);
        chk("full_len",  64'(out_len),  64'd32);
        chk("full_mask", 64'(out_mask), 64'b1111);
        tick();
        chk("full_beat_cnt", 64'(beat_cnt), 64'd2);

        // Backpressure: pipe holds exactly two beats
        out_ready = 1'b0;
        frag(0, 1'b1, 4'd8, 8'h01);
        #1;
        chk("bp_ready_b1", 64'(in_ready), 64'd1);
        tick();
        frag(0, 1'b1, 4'd8, 8'h02);
        #1;
        chk("bp_ready_b2", 64'(in_ready), 64'd1);
        tick();
        frag(0, 1'b1, 4'd8, 8'h03);
        #1;
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data",  64'(out_data),  64'h01);
        tick();
        chk("bp_stable_data",  64'(out_data), 64'h01);
        chk("bp_stable_len",   64'(out_len),  64'd8);
        chk("bp_stable_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 64'(in_ready), 64'd1);
        tick();
        clr();
        chk("bp_beat2_valid", 64'(out_valid), 64'd1);
        chk("bp_beat2_data",  64'(out_data),  64'h02);
        tick();
        chk("bp_beat3_valid", 64'(out_valid), 64'd1);
        chk("bp_beat3_data",  64'(out_data),  64'h03);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);
        // two earlier beats plus three here
        chk("bp_beat_cnt", 64'(beat_cnt), 64'd5);

        // Length error: in1 len 12 clamps to 8 and shifts in2 to offset 12
        frag(0, 1'b1, 4'd4,  8'h0A);
        frag(1, 1'b1, 4'd12, 8'hFF);
        frag(2, 1'b1, 4'd4,  8'h03);
        #1;
        chk("lerr_before", 64'(err_len), 64'd0);
        tick();
        clr();
        chk("lerr_set", 64'(err_len), 64'd1);
        tick();
        chk("lerr_data", 64'(out_data), 64'h3FFA);
        chk("lerr_len",  64'(out_len),  64'd16);
        chk("lerr_mask", 64'(out_mask), 64'b0111);
        frag(0, 1'b1, 4'd8, 8'h5A);
        tick();
        clr();
        tick();
        chk("lerr_clean_data", 64'(out_data), 64'h5A);
        chk("lerr_sticky",     64'(err_len),  64'd1);
        tick();
        chk("lerr_beat_cnt", 64'(beat_cnt), 64'd7);

        // No valid inputs: nothing accepted, nothing emitted
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("novalid_out_valid", 64'(out_valid), 64'd0);
        end
        chk("novalid_beat_cnt", 64'(beat_cnt), 64'd7);

        // Zero-length beat is delivered and counted
        frag(0, 1'b1, 4'd0, 8'hFF);
        tick();
        clr();
        tick();
        chk("zlen_valid", 64'(out_valid), 64'd1);
        chk("zlen_len",   64'(out_len),   64'd0);
        chk("zlen_data",  64'(out_data),  64'd0);
        chk("zlen_mask",  64'(out_mask),  64'b0001);
        tick();
        chk("zlen_beat_cnt", 64'(beat_cnt), 64'd8);

        // Mid-flight reset with two beats held in the pipe
        out_ready = 1'b0;
        frag(0, 1'b1, 4'd8, 8'h11);
        tick();
        frag(0, 1'b1, 4'd8, 8'h22);
        tick();
        clr();
        chk("mrst_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mrst_valid",    64'(out_valid), 64'd0);
        chk("mrst_beat_cnt", 64'(beat_cnt),  64'd0);
        chk("mrst_err_len",  64'(err_len),   64'd0);
        chk("mrst_in_ready", 64'(in_ready),  64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mrst_ready_after", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mrst_no_stale", 64'(out_valid), 64'd0);
        end
        chk("mrst_final_cnt", 64'(beat_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
